dmem_bank: RTL

//   Parametrised byte-addressable data memory for the NPC core.
//   - Sized load/store with request/response valid-ready handshake and configurable read latency.
//   - Generates byte-lane write strobes from size and address offset.
//   - Sign- or zero-extends loads to DW bits.
//   - Flags misaligned accesses with an error response instead of touching memory.
//   - Sits between the core LSU and the simulation memory image.
//

---
 rtl/dmem_bank.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dmem_bank.sv
// dmem_bank - byte-addressable data memory sitting between the core LSU and
// the simulation memory image.
//
// A single request is in flight at a time. Stores commit on the accept edge.
// Loads sample the addressed word on the accept edge, then extract and extend
// the addressed field. The response appears LATENCY cycles after the accept
// cycle and is held until the consumer takes it. Misaligned accesses, and
// sizes wider than the data word, return an error and do not touch memory.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high (memory is not cleared)
//   req_valid  in   1      request present
//   req_ready  out  1      high exactly when idle
//   req_we     in   1      1 = store, 0 = load
//   req_addr   in   AW+OW  byte address
//   req_size   in   2      0 byte, 1 half, 2 word, 3 dword
//   req_signed in   1      load sign-extend (1) / zero-extend (0)
//   req_wdata  in   DW     right-aligned store data
//   rsp_valid  out  1      response present
//   rsp_ready  in   1      consumer takes response
//   rsp_rdata  out  DW     extended load data, 0 for stores and errors
//   rsp_err    out  1      misaligned or unsupported size
module dmem_bank #(
    parameter  int DW      = 64,
    parameter  int AW      = 16,
    parameter  int LATENCY = 1,
    localparam int OW      = $clog2(DW / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AW+OW-1:0]     req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err
);

    localparam int NB = DW / 8;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem_q [2**AW];

    logic [OW-1:0]   off;
    logic [AW-1:0]   idx;
    logic            accept;
    logic            req_err;
    logic [NB-1:0]   strb;
    logic [DW-1:0]   wdata_sh;
    logic [DW-1:0]   ld_val;

    function automatic logic size_err(input logic [1:0] size, input logic [OW-1:0] o);
        int nb;
        nb = 1 << size;
        return (nb > NB) || ((int'(o) & (nb - 1)) != 0);
    endfunction

    function automatic logic [NB-1:0] lane_strobe(input logic [1:0] size, input logic [OW-1:0] o);
        logic [NB-1:0] s;
        int nb;
        nb = 1 << size;
        for (int k = 0; k < NB; k++) begin
            s[k] = (k >= int'(o)) && (k < int'(o) + nb);
        end
        return s;
    endfunction

    // Shift the addressed field down to bit 0, then mask to the access size
    // and either fill the upper bits with the field's msb or clear them.
    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] word, input logic [OW-1:0] o,
                                               input logic [1:0] size, input logic sgn);
        logic [DW-1:0] sh;
        logic [DW-1:0] mask;
        int            nbits;
        int            msb_i;
        sh    = word >> {o, 3'b000};
        nbits = 8 << size;
        mask  = ~({DW{1'b1}} << nbits);
        msb_i = (nbits > DW) ? DW - 1 : nbits - 1;
        if (sgn && sh[msb_i]) begin
            return sh | ~mask;
        end
        return sh & mask;
    endfunction

    assign off      = req_addr[OW-1:0];
    assign idx      = req_addr[AW+OW-1:OW];
    assign accept   = req_valid & req_ready;
    assign req_err  = size_err(req_size, off);
    assign strb     = lane_strobe(req_size, off);
    assign wdata_sh = req_wdata << {off, 3'b000};
    assign ld_val   = load_ext(mem_q[idx], off, req_size, req_signed);

    // Memory has no reset; a store accepted before a reset stays committed.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int k = 0; k < NB; k++) begin
                if (strb[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = (req_we || req_err) ? '0 : ld_val;
                    err_d   = req_err;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Counter reaching 0 on this edge puts RESP exactly LATENCY
                // cycles after the accept cycle.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule
